// File: rtl/regfile_pkg.sv
// Shared register-file constants and the dump-reader FSM state type.
package regfile_pkg;

    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dump_state_t;

endpackage

// File: rtl/reg_dump_reader.sv
// Walks the register-file read port over all registers and streams each
// captured word out on a valid/ready interface with index and last flags.
module reg_dump_reader
    import regfile_pkg::*;
#(
    parameter int DATA_W   = REG_DATA_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_REGS = REG_COUNT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    dump_state_t       state;
    dump_state_t       state_nxt;
    logic [ADDR_W-1:0] idx;
    logic              handshake;

    assign handshake = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        rd_addr   = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                busy      = 1'b1;
                rd_addr   = idx;
                state_nxt = SEND;
            end
            SEND: begin
                busy    = 1'b1;
                rd_addr = idx;
                if (handshake) begin
                    state_nxt = out_last ? DONE : READ;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture happens at the READ edge, so a write landing on that same edge is not seen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx <= '0;
                    end
                end
                READ: begin
                    out_data  <= rd_data;
                    out_index <= idx;
                    out_last  <= (idx == LAST_IDX);
                    out_valid <= 1'b1;
                end
                SEND: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        if (!out_last) begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench: a behavioural register file plus beat monitors, checked
// against the register contents expected at each beat's capture time.
module tb_reg_dump_reader;
    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [AW-1:0] i;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n, start, out_ready;
    logic          busy, done, out_valid, out_last;
    logic [AW-1:0] rd_addr, out_index;
    logic [DW-1:0] rd_data, out_data;

    logic          start_b, busy_b, done_b, valid_b, last_b;
    logic [AW-1:0] rd_addr_b, index_b;
    logic [DW-1:0] rd_data_b, data_b;

    logic [DW-1:0] regs [32];
    logic [DW-1:0] mdl  [32];
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (we) regs[wa] <= wd;
    assign rd_data   = regs[rd_addr];
    assign rd_data_b = regs[rd_addr_b];

    reg_dump_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
        .out_last(out_last)
    );

    reg_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .out_valid(valid_b),
        .out_ready(1'b1), .out_data(data_b), .out_index(index_b),
        .out_last(last_b)
    );

    // Monitors: record accepted beats, hold-stability violations and done pulses.
    int    cyc = 0;
    beat_t q[$];
    beat_t qb[$];
    int    done_cnt, done_cyc, hs_cyc, fv_cyc, stab_err;
    int    done_cnt_b, hs_cyc_b;
    logic  stall_p = 1'b0;
    beat_t held;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (stall_p && (!out_valid || {out_data, out_index, out_last} != held)) stab_err++;
        stall_p = out_valid && !out_ready;
        held    = {out_data, out_index, out_last};
        if (out_valid && out_ready) begin
            q.push_back({out_data, out_index, out_last});
            hs_cyc = cyc;
        end
        if (out_valid && fv_cyc < 0) fv_cyc = cyc;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (valid_b) begin
            qb.push_back({data_b, index_b, last_b});
            hs_cyc_b = cyc;
        end
        if (done_b) done_cnt_b++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic arm;
        q.delete();
        qb.delete();
        done_cnt = 0; done_cyc = -1; hs_cyc = -1; fv_cyc = -1; stab_err = 0;
        done_cnt_b = 0; hs_cyc_b = -1;
    endtask

    task automatic preload(input bit rnd);
        we = 1'b1;
        for (int i = 0; i < 32; i++) begin
            wa = AW'(i);
            wd = rnd ? $urandom : 32'hA000_0000 + i;
            mdl[i] = wd;
            tick;
        end
        we = 1'b0;
    endtask

    // Returns with s0 = edge count before the edge that samples start.
    task automatic pulse_start(output int s0);
        start = 1'b1;
        @(negedge clk);
        s0 = cyc;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && done_cnt == 0; k++) tick;
        n_cmp++;
        if (done_cnt == 0) begin
            n_err++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
        repeat (4) tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; start_b = 1'b0; out_ready = 1'b0; we = 1'b0;
        wa = '0; wd = '0;
        repeat (2) tick;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (rd_addr !== '0) begin n_err++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", out_data); end
        n_cmp++; if (out_index !== '0) begin n_err++; $display("FAIL reset_index: got %0d want 0", out_index); end
        n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b want 0", out_last); end
        tick;
    endtask

    task automatic check_beats(input string nm, input int n);
        n_cmp++;
        if (q.size() != n) begin
            n_err++;
            $display("FAIL %s_count: got %0d beats want %0d", nm, q.size(), n);
        end
        for (int i = 0; i < n && i < q.size(); i++) begin
            n_cmp++;
            if (q[i] !== beat_t'({mdl[i], AW'(i), i == n - 1})) begin
                n_err++;
                $display("FAIL %s_beat%0d: got d=%h i=%0d l=%b want d=%h i=%0d l=%b",
                         nm, i, q[i].d, q[i].i, q[i].l, mdl[i], i, i == n - 1);
            end
        end
    endtask

    task automatic test_sequential;
        int s0;
        preload(1'b0);
        out_ready = 1'b1;
        arm;
        pulse_start(s0);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL seq_busy_running: got %b want 1", busy); end
        wait_done(200);
        check_beats("seq", 32);
        n_cmp++; if (fv_cyc != s0 + 2) begin n_err++; $display("FAIL seq_first_valid: got %0d want %0d", fv_cyc - s0, 2); end
        n_cmp++; if (hs_cyc != s0 + 64) begin n_err++; $display("FAIL seq_span: got %0d want 64", hs_cyc - s0); end
        n_cmp++; if (done_cyc != hs_cyc + 1) begin n_err++; $display("FAIL seq_done_timing: got %0d want %0d", done_cyc, hs_cyc + 1); end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL seq_done_count: got %0d want 1", done_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL seq_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_backpressure;
        int s0;
        int stalls = 0;
        preload(1'b1);
        out_ready = 1'b1;
        arm;
        pulse_start(s0);
        for (int k = 0; k < 400 && done_cnt == 0; k++) begin
            if (q.size() == 3 && out_valid && stalls < 5) begin
                out_ready = 1'b0;
                stalls++;
            end else if (stalls >= 5) begin
                out_ready = ~out_ready;
            end else begin
                out_ready = 1'b1;
            end
            tick;
        end
        out_ready = 1'b1;
        wait_done(50);
        check_beats("bp", 32);
        n_cmp++; if (stalls != 5) begin n_err++; $display("FAIL bp_stalls: got %0d want 5", stalls); end
        n_cmp++; if (stab_err != 0) begin n_err++; $display("FAIL bp_hold: got %0d changes want 0", stab_err); end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_start_busy;
        int s0;
        out_ready = 1'b1;
        arm;
        pulse_start(s0);
        for (int k = 0; k < 100 && q.size() < 10; k++) tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        wait_done(200);
        repeat (6) tick;
        check_beats("sb", 32);
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL sb_done_count: got %0d want 1", done_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL sb_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_concurrent_write;
        int s0;
        preload(1'b0);
        out_ready = 1'b1;
        // write lands on the edge that captures index 7
        arm;
        pulse_start(s0);
        repeat (14) tick;
        we = 1'b1; wa = 5'd7; wd = 32'hDEAD_BEEF;
        tick;
        we = 1'b0;
        wait_done(200);
        n_cmp++;
        if (q.size() < 9 || q[7].d !== 32'hA000_0007) begin
            n_err++; $display("FAIL cw_same_edge: got %h want a0000007", q.size() > 7 ? q[7].d : '0);
        end
        n_cmp++;
        if (q.size() < 9 || q[8].d !== 32'hA000_0008) begin
            n_err++; $display("FAIL cw_neighbour: got %h want a0000008", q.size() > 8 ? q[8].d : '0);
        end
        // restore, then write one edge earlier
        we = 1'b1; wa = 5'd7; wd = 32'hA000_0007;
        tick;
        we = 1'b0;
        arm;
        pulse_start(s0);
        repeat (13) tick;
        we = 1'b1; wa = 5'd7; wd = 32'hDEAD_BEEF;
        tick;
        we = 1'b0;
        mdl[7] = 32'hDEAD_BEEF;
        wait_done(200);
        n_cmp++;
        if (q.size() < 8 || q[7].d !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL cw_early: got %h want deadbeef", q.size() > 7 ? q[7].d : '0);
        end
    endtask

    task automatic test_reset_mid;
        int s0;
        preload(1'b1);
        out_ready = 1'b1;
        arm;
        pulse_start(s0);
        for (int k = 0; k < 100 && q.size() < 15; k++) tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, rd_addr, out_valid, out_data, out_index, out_last} !== '0) begin
            n_err++;
            $display("FAIL rm_outputs: got busy=%b done=%b addr=%0d v=%b d=%h i=%0d l=%b want all 0",
                     busy, done, rd_addr, out_valid, out_data, out_index, out_last);
        end
        repeat (5) tick;
        n_cmp++; if (done_cnt != 0) begin n_err++; $display("FAIL rm_no_done: got %0d want 0", done_cnt); end
        arm;
        pulse_start(s0);
        wait_done(200);
        n_cmp++;
        if (q.size() == 0 || q[0].i !== '0) begin
            n_err++; $display("FAIL rm_restart_index: got %0d want 0", q.size() > 0 ? q[0].i : '1);
        end
        check_beats("rm", 32);
    endtask

    task automatic test_small;
        int s0;
        preload(1'b1);
        arm;
        start_b = 1'b1;
        @(negedge clk);
        s0 = cyc;
        tick;
        start_b = 1'b0;
        for (int k = 0; k < 50 && done_cnt_b == 0; k++) tick;
        repeat (4) tick;
        n_cmp++; if (qb.size() != 4) begin n_err++; $display("FAIL n4_count: got %0d want 4", qb.size()); end
        for (int i = 0; i < 4 && i < qb.size(); i++) begin
            n_cmp++;
            if (qb[i] !== beat_t'({mdl[i], AW'(i), i == 3})) begin
                n_err++;
                $display("FAIL n4_beat%0d: got d=%h i=%0d l=%b want d=%h i=%0d l=%b",
                         i, qb[i].d, qb[i].i, qb[i].l, mdl[i], i, i == 3);
            end
        end
        n_cmp++; if (hs_cyc_b - s0 != 8) begin n_err++; $display("FAIL n4_span: got %0d want 8", hs_cyc_b - s0); end
        n_cmp++; if (done_cnt_b != 1) begin n_err++; $display("FAIL n4_done_count: got %0d want 1", done_cnt_b); end
    endtask

    initial begin
        test_reset;
        test_sequential;
        test_backpressure;
        test_start_busy;
        test_concurrent_write;
        test_reset_mid;
        test_small;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
